// File: rtl/counter_pkg.sv
// Shared constants for the generic timer/event counter family.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_PRESCALE_W = 8;

endpackage

// File: rtl/prescale_tick.sv
// Prescaler: emits one tick every (prescale+1) enabled cycles; restart zeroes the phase.
module prescale_tick #(
  parameter int PRESCALE_W = counter_pkg::DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  restart,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] pre_cnt_q;
  logic [PRESCALE_W-1:0] pre_cnt_d;

  assign tick = en && (pre_cnt_q == prescale);

  // A phase left above a newly lowered prescale runs on and wraps through zero.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (restart) begin
      pre_cnt_d = '0;
    end else if (en) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/counter_mod_n.sv
// Up/down modulo-limit counter with wrap or saturate, prescaled stepping,
// sync clear/load, terminal-count pulse and sticky overflow.
module counter_mod_n
  import counter_pkg::*;
#(
  parameter int                WIDTH      = DEF_WIDTH,
  parameter logic [WIDTH-1:0]  RESET_VAL  = '0,
  parameter int                SATURATE   = MODE_WRAP,
  parameter int                PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  dir,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  ovf_sticky,
  output logic                  at_zero,
  output logic                  at_limit
);

  localparam logic             SAT_MODE = (SATURATE == MODE_SAT);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic             tick;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  prescale_tick #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescale (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .restart  (clr | load),
    .prescale (prescale),
    .tick     (tick)
  );

  // clr beats load beats step; tc only ever survives one cycle.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = load_val;
    end else if (tick) begin
      if (dir == DIR_UP) begin
        // >= so a count above a lowered limit (or loaded past it) still hits the boundary
        if (count_q >= limit) begin
          count_d = SAT_MODE ? limit : '0;
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          count_d = count_q + ONE;
        end
      end else begin
        if (count_q == '0) begin
          count_d = SAT_MODE ? '0 : limit;
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          count_d = count_q - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= RESET_VAL;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count      = count_q;
  assign tc         = tc_q;
  assign ovf_sticky = ovf_q;
  assign at_zero    = (count_q == '0);
  assign at_limit   = (count_q == limit);

endmodule

// File: tb/tb_counter_mod_n.sv
// Directed bench for counter_mod_n: a wrap instance and a saturate instance share stimulus.
module tb_counter_mod_n;

  localparam int W  = 8;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          en, clr, load, dir;
  logic [W-1:0]  load_val, limit;
  logic [PW-1:0] prescale;

  logic [W-1:0] count_w, count_s;
  logic         tc_w, tc_s, ovf_w, ovf_s, az_w, az_s, al_w, al_s;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  counter_mod_n #(.WIDTH(W), .RESET_VAL(8'd0), .SATURATE(0), .PRESCALE_W(PW)) dut_w (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .dir(dir), .limit(limit), .prescale(prescale), .count(count_w), .tc(tc_w),
    .ovf_sticky(ovf_w), .at_zero(az_w), .at_limit(al_w));

  counter_mod_n #(.WIDTH(W), .RESET_VAL(8'd3), .SATURATE(1), .PRESCALE_W(PW)) dut_s (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .dir(dir), .limit(limit), .prescale(prescale), .count(count_s), .tc(tc_s),
    .ovf_sticky(ovf_s), .at_zero(az_s), .at_limit(al_s));

  typedef struct {
    logic         en, clr, load, dir;
    logic [W-1:0] load_val, limit;
    logic [W-1:0] exp_count;
    logic         exp_tc, exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic c, input logic l, input logic d,
                       input logic [W-1:0] lv, input logic [W-1:0] lim);
    en = e; clr = c; load = l; dir = d; load_val = lv; limit = lim;
  endtask

  vec_t vecs[$];

  initial begin
    reset = 1'b0; prescale = '0;
    drive(0, 0, 0, 1, 0, 0);

    // Reset state and idle hold
    #12;
    check("rst_count_w", count_w, 0);
    check("rst_count_s", count_s, 3);
    check("rst_tc", {tc_w, tc_s}, 0);
    check("rst_ovf", {ovf_w, ovf_s}, 0);
    #5 reset = 1'b1;
    repeat (10) edge_step();
    check("idle_count_w", count_w, 0);
    check("idle_count_s", count_s, 3);
    check("idle_at_zero_w", az_w, 1);

    // Wrap instance table: clr, count-to-5 wrap, limit=0, load, down wrap
    vecs.push_back('{1,1,0,1, 0,5, 0,0,0});
    vecs.push_back('{1,0,0,1, 0,5, 1,0,0});
    vecs.push_back('{1,0,0,1, 0,5, 2,0,0});
    vecs.push_back('{1,0,0,1, 0,5, 3,0,0});
    vecs.push_back('{1,0,0,1, 0,5, 4,0,0});
    vecs.push_back('{1,0,0,1, 0,5, 5,0,0});
    vecs.push_back('{1,0,0,1, 0,5, 0,1,1});
    vecs.push_back('{1,0,0,1, 0,5, 1,0,1});
    vecs.push_back('{1,0,0,1, 0,5, 2,0,1});
    vecs.push_back('{0,1,0,1, 0,5, 0,0,0});
    vecs.push_back('{1,0,0,1, 0,0, 0,1,1});
    vecs.push_back('{1,0,0,1, 0,0, 0,1,1});
    vecs.push_back('{1,0,0,0, 0,0, 0,1,1});
    vecs.push_back('{1,0,1,0, 7,9, 7,0,1});
    vecs.push_back('{1,0,0,0, 7,9, 6,0,1});
    vecs.push_back('{1,0,1,0, 0,9, 0,0,1});
    vecs.push_back('{1,0,0,0, 0,9, 9,1,1});
    vecs.push_back('{1,0,0,1, 0,9, 0,1,1});
    vecs.push_back('{0,0,0,1, 0,9, 0,0,1});
    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].clr, vecs[i].load, vecs[i].dir, vecs[i].load_val, vecs[i].limit);
      edge_step();
      check($sformatf("vec%0d_count", i), count_w, vecs[i].exp_count);
      check($sformatf("vec%0d_tc", i), tc_w, vecs[i].exp_tc);
      check($sformatf("vec%0d_ovf", i), ovf_w, vecs[i].exp_ovf);
    end

    // Saturate down from 2: 1,0,0,0 with tc on each tick held at 0
    drive(0, 1, 0, 0, 0, 9); edge_step();
    drive(1, 0, 1, 0, 2, 9); edge_step();
    check("sat_load", count_s, 2);
    drive(1, 0, 0, 0, 2, 9);
    for (int k = 0; k < 4; k++) begin
      edge_step();
      check($sformatf("sat_dn%0d_count", k), count_s, (k == 0) ? 1 : 0);
      check($sformatf("sat_dn%0d_tc", k), tc_s, (k >= 2) ? 1 : 0);
    end
    check("sat_ovf", ovf_s, 1);
    drive(1, 1, 0, 0, 0, 9); edge_step();
    check("sat_clr_count", count_s, 0);
    check("sat_clr_ovf", ovf_s, 0);
    check("sat_clr_tc", tc_s, 0);

    // Prescale 3: step every 4th edge, then a 2-cycle en gap stretches to 6
    prescale = 8'd3;
    drive(1, 1, 0, 1, 0, 100); edge_step();
    drive(1, 0, 0, 1, 0, 100);
    for (int k = 1; k <= 4; k++) begin
      edge_step();
      check($sformatf("pre_a%0d", k), count_w, (k == 4) ? 1 : 0);
    end
    for (int k = 1; k <= 6; k++) begin
      en = (k == 3 || k == 4) ? 1'b0 : 1'b1;
      edge_step();
      check($sformatf("pre_b%0d", k), count_w, (k == 6) ? 2 : 1);
    end
    prescale = 8'd0;

    // clr and load on a ticking edge, then load above limit
    drive(1, 1, 1, 1, 55, 100); edge_step();
    check("clrld_count_w", count_w, 0);
    check("clrld_tc_w", tc_w, 0);
    check("clrld_count_s", count_s, 0);
    drive(1, 0, 1, 1, 200, 100); edge_step();
    check("ld200_count", count_w, 200);
    drive(1, 0, 0, 1, 200, 100); edge_step();
    check("over_wrap_count", count_w, 0);
    check("over_wrap_tc", tc_w, 1);
    check("over_sat_count", count_s, 100);
    check("over_sat_tc", tc_s, 1);
    edge_step();
    check("sat_hold_count", count_s, 100);
    check("sat_hold_tc", tc_s, 1);
    check("sat_at_limit", al_s, 1);

    // Async reset between edges at count=37
    drive(1, 0, 1, 1, 35, 100); edge_step();
    drive(1, 0, 0, 1, 35, 100); edge_step(); edge_step();
    check("pre_rst_count", count_w, 37);
    #1 reset = 1'b0;
    #1;
    check("async_rst_count_w", count_w, 0);
    check("async_rst_count_s", count_s, 3);
    check("async_rst_ovf", {ovf_w, ovf_s}, 0);
    #4 reset = 1'b1;
    edge_step();
    check("resume_count_w", count_w, 1);
    check("resume_count_s", count_s, 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
